// File: rtl/matrix_operand_loader.sv
// Gathers a 2x2 A and a 2x2 B operand (four signed bytes each) from the register file,
// one read per cycle, and holds them for the matrix multiplier until it acknowledges.
module matrix_operand_loader #(
    parameter logic [2:0] A_BASE = 3'd0,
    parameter logic [2:0] B_BASE = 3'd4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    output logic              rd_en,
    output logic [2:0]        rd_addr,
    input  logic signed [7:0] rd_data,
    output logic [31:0]       A,
    output logic [31:0]       B,
    output logic              operands_valid,
    input  logic              mult_ack,
    output logic              busy,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [55:0] buf_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        valid_q;

    logic [31:0] a_d;
    logic [31:0] b_d;
    logic [2:0]  addr_d;

    // Slots 0..6 arrive through a right-shifting buffer; slot 7 is taken straight from rd_data.
    always_comb begin
        a_d    = buf_q[31:0];
        b_d    = {rd_data, buf_q[55:32]};
        addr_d = idx_q[2] ? (B_BASE + {1'b0, idx_q[1:0]})
                          : (A_BASE + {1'b0, idx_q[1:0]});
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            buf_q   <= 56'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            valid_q <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= 3'd0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (idx_q == 3'd7) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        valid_q <= 1'b1;
                        idx_q   <= 3'd0;
                        state_q <= VALID;
                    end else begin
                        buf_q <= {rd_data, buf_q[55:8]};
                        idx_q <= idx_q + 3'd1;
                    end
                end
                VALID: begin
                    if (mult_ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= 3'd0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Read port is driven only while gathering; it parks at address 0 otherwise.
    assign rd_en          = (state_q == READ);
    assign rd_addr        = (state_q == READ) ? addr_d : 3'd0;
    assign A              = a_q;
    assign B              = b_q;
    assign operands_valid = valid_q;
    assign busy           = (state_q != IDLE);
    assign stall_req      = (state_q != IDLE) && !valid_q;

endmodule
